// File: rtl/tdm_demux_1x8_if.sv
// Bus bundle for the 1-to-8 TDM demultiplexer: serial input side, selects,
// and the eight registered parallel outputs with frame status.
interface tdm_demux_1x8_if;
  logic       i_din;
  logic       i_en;
  logic       i_sync;
  logic       i_mode;
  logic       i_s0;
  logic       i_s1;
  logic       i_s2;
  logic       o_o0;
  logic       o_o1;
  logic       o_o2;
  logic       o_o3;
  logic       o_o4;
  logic       o_o5;
  logic       o_o6;
  logic       o_o7;
  logic [2:0] o_slot;
  logic       o_frame_done;
  logic       o_err;

  modport master (
    output i_din, i_en, i_sync, i_mode, i_s0, i_s1, i_s2,
    input  o_o0, o_o1, o_o2, o_o3, o_o4, o_o5, o_o6, o_o7,
    input  o_slot, o_frame_done, o_err
  );

  modport slave (
    input  i_din, i_en, i_sync, i_mode, i_s0, i_s1, i_s2,
    output o_o0, o_o1, o_o2, o_o3, o_o4, o_o5, o_o6, o_o7,
    output o_slot, o_frame_done, o_err
  );
endinterface

// File: rtl/tdm_demux_1x8.sv
// Sequential 1-to-8 demultiplexer: framed mode assembles 8 slots in a shadow
// register and loads all outputs at once; direct mode writes one output.
//
// state   | meaning
// ST_IDLE | waiting for an EN-qualified SYNC bit (slot 0)
// ST_RUN  | collecting slots 1..7 into the shadow register
module tdm_demux_1x8 #(
  parameter bit AUTO_RESYNC = 1'b1
) (
  input logic            i_clk,
  input logic            i_rst,
  tdm_demux_1x8_if.slave bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t     r_state, w_state_nxt;
  logic [7:0] r_shadow, w_shadow_nxt;
  logic [7:0] r_out, w_out_nxt;
  logic [2:0] r_slot, w_slot_nxt;
  logic       r_done, w_done_nxt;
  logic       r_err, w_err_nxt;
  logic [2:0] w_sel;

  assign w_sel = {bus.i_s2, bus.i_s1, bus.i_s0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_out    <= '0;
      r_slot   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shadow <= w_shadow_nxt;
      r_out    <= w_out_nxt;
      r_slot   <= w_slot_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Direct mode always parks the framer in IDLE, which also aborts a frame.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.i_mode) begin
      w_state_nxt = ST_IDLE;
    end else if (bus.i_en) begin
      case (r_state)
        ST_IDLE: if (bus.i_sync) w_state_nxt = ST_RUN;
        ST_RUN: begin
          if (bus.i_sync)
            w_state_nxt = AUTO_RESYNC ? ST_RUN : ST_IDLE;
          else if (r_slot == 3'd7)
            w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_shadow_nxt = r_shadow;
    w_out_nxt    = r_out;
    w_slot_nxt   = r_slot;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
    if (bus.i_mode) begin
      w_shadow_nxt = '0;
      w_slot_nxt   = '0;
      if (bus.i_en) w_out_nxt[w_sel] = bus.i_din;
    end else if (bus.i_en) begin
      if (r_state == ST_IDLE) begin
        if (bus.i_sync) begin
          w_shadow_nxt = {7'd0, bus.i_din};
          w_slot_nxt   = 3'd1;
        end
      end else if (bus.i_sync) begin
        // A SYNC inside RUN is always mid-frame, including on the slot-7 bit.
        w_err_nxt = 1'b1;
        if (AUTO_RESYNC) begin
          w_shadow_nxt = {7'd0, bus.i_din};
          w_slot_nxt   = 3'd1;
        end else begin
          w_shadow_nxt = '0;
          w_slot_nxt   = '0;
        end
      end else if (r_slot == 3'd7) begin
        w_out_nxt  = {bus.i_din, r_shadow[6:0]};
        w_done_nxt = 1'b1;
        w_slot_nxt = '0;
      end else begin
        w_shadow_nxt[r_slot] = bus.i_din;
        w_slot_nxt           = r_slot + 3'd1;
      end
    end
  end

  assign bus.o_o0         = r_out[0];
  assign bus.o_o1         = r_out[1];
  assign bus.o_o2         = r_out[2];
  assign bus.o_o3         = r_out[3];
  assign bus.o_o4         = r_out[4];
  assign bus.o_o5         = r_out[5];
  assign bus.o_o6         = r_out[6];
  assign bus.o_o7         = r_out[7];
  assign bus.o_slot       = r_slot;
  assign bus.o_frame_done = r_done;
  assign bus.o_err        = r_err;

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Sequential 1-to-8 demultiplexer: the receive-side counterpart of the 8x1 select mux.
- Accepts a serial bit stream on IN and steers each bit to one of eight registered outputs O0..O7.
- Framed mode: an internal slot counter fills a shadow register, and all eight outputs update together when the frame completes.
- Direct mode: external selects S2..S0 write a single output.
- Used wherever a muxed/TDM line must be fanned back out to parallel signals.

Parameters:
AUTO_RESYNC, 1, 1 = a SYNC mid-frame restarts a frame using that bit as slot 0; 0 = mid-frame SYNC aborts to IDLE and the bit is discarded.

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous reset, active-high
IN  input  1  serial data bit
EN  input  1  IN is valid this cycle
SYNC  input  1  marks IN as slot 0 of a frame (qualified by EN)
MODE  input  1  0 = framed (counter-driven), 1 = direct (S2..S0-driven)
S0  input  1  direct-mode select LSB
S1  input  1  direct-mode select
S2  input  1  direct-mode select MSB
O0..O7  output  1 each  registered demuxed outputs; Ok carries slot/select k
SLOT  output  3  next slot to be written in framed mode
FRAME_DONE  output  1  one-cycle pulse: O0..O7 were just loaded from a complete frame
ERR  output  1  one-cycle pulse: SYNC received with SLOT != 0 while in RUN

Behaviour:
- Reset (RST high, asynchronous):
  - O0..O7 = 0, shadow = 0, SLOT = 0.
  - FRAME_DONE = 0, ERR = 0, state = IDLE.
  - Reset mid-frame discards partial data.
- Select encoding: {S2,S1,S0} = k selects Ok. Slot k of a frame maps to Ok.
- All outputs are registered. FRAME_DONE and ERR are high for exactly one cycle per event.
- Direct mode (MODE = 1):
  - EN = 1: Ok <= IN at the next edge for k = {S2,S1,S0}; all other outputs hold.
  - EN = 0: all outputs hold.
  - Latency is 1 cycle.
  - State is forced to IDLE, SLOT = 0, shadow = 0.
  - FRAME_DONE and ERR stay 0.
- Framed mode (MODE = 0), two states, IDLE and RUN:
  - IDLE:
    - EN & SYNC: shadow[0] <= IN, SLOT <= 1, go to RUN.
    - Anything else: hold. EN without SYNC is ignored; SYNC without EN is ignored.
  - RUN, EN = 0: hold everything (gaps between bits are allowed, with no timeout).
  - RUN, EN = 1, SYNC = 0, SLOT < 7: shadow[SLOT] <= IN, SLOT <= SLOT + 1.
  - RUN, EN = 1, SYNC = 0, SLOT = 7:
    - O0..O6 <= shadow[0..6] and O7 <= IN, all on the same edge.
    - FRAME_DONE <= 1, SLOT wraps to 0, go to IDLE.
  - RUN, EN = 1, SYNC = 1 (always mid-frame, since SLOT >= 1 in RUN):
    - ERR <= 1 and shadow is cleared.
    - AUTO_RESYNC = 1: shadow[0] <= IN, SLOT <= 1, stay in RUN.
    - AUTO_RESYNC = 0: SLOT <= 0, go to IDLE.
    - O0..O7 hold in both cases.
  - SYNC together with EN on the slot-7 bit counts as mid-frame: ERR, no frame load.
- Back-to-back frames: a SYNC bit arriving the cycle after FRAME_DONE is accepted normally, so there is zero dead time.
- O0..O7 change only on frame completion (framed) or a direct write. A partial frame never reaches the outputs.
- MODE 0->1 mid-frame: the frame is aborted (shadow cleared, SLOT = 0, IDLE), no ERR, and the outputs hold before the first direct write.
- MODE 1->0: the next cycle starts in IDLE.

Test Plan:
- Reset, then MODE=0 with 8 consecutive EN cycles carrying IN = 1,0,1,0,1,0,1,0 and SYNC on the first -> FRAME_DONE pulses on the 8th edge; O0..O7 = 1,0,1,0,1,0,1,0; SLOT = 0; O0..O7 stay 0 before that edge.
- Same frame with EN low for 3 cycles between bit 3 and bit 4 -> SLOT holds at 4 during the gap; identical final outputs; FRAME_DONE only after the 8th valid bit.
- Frame A = all 1s immediately followed by frame B = 0,1,0,1,0,1,0,1 -> two FRAME_DONE pulses 8 cycles apart; outputs equal A, then B.
- SYNC with EN at SLOT = 5 -> ERR pulse, outputs unchanged. With AUTO_RESYNC=1: SLOT = 1 and the following 7 bits complete a frame. With AUTO_RESYNC=0: IDLE, SLOT = 0.
- MODE=1, EN=1, IN=1 with {S2,S1,S0} stepped 000..111, then IN=0 at 011 -> each Ok rises one cycle after its select; O3 returns to 0; FRAME_DONE and ERR stay 0.
- Assert RST asynchronously between clock edges mid-frame (SLOT = 4) -> all outputs and SLOT read 0 immediately; the next SYNC frame completes correctly.
